// File: rtl/rr_lock_arbiter_pkg.sv
// Shared types and limits for the round-robin lock arbiter.
package rr_lock_arbiter_pkg;

  localparam int RR_MAX_REQ = 32;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } ArbState_t;

endpackage

// File: rtl/rr_lock_arbiter_prefix_red.sv
// Prefix reduction: out_o[i] reduces in_i from the START end up to bit i.
// FUNC 0 = OR, otherwise AND; START 0 = from bit 0 upward, otherwise from the MSB downward.
module PrefixRed
  import rr_lock_arbiter_pkg::*;
#(
  parameter int W     = 8,
  parameter int FUNC  = 0,
  parameter int START = 0
) (
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);

  logic acc;

  always_comb begin
    out_o = '0;
    acc   = (FUNC == 0) ? 1'b0 : 1'b1;
    if (START == 0) begin
      for (int i = 0; i < W; i++) begin
        acc      = (FUNC == 0) ? (acc | in_i[i]) : (acc & in_i[i]);
        out_o[i] = acc;
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        acc      = (FUNC == 0) ? (acc | in_i[i]) : (acc & in_i[i]);
        out_o[i] = acc;
      end
    end
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with a grant lock that holds the resource for multi-beat transfers.
//   state      | meaning
//   ARB_IDLE   | free; winner is the first request at or after ptr, wrapping around
//   ARB_LOCKED | owner is mid-transfer; only the owner may be granted
module rr_lock_arbiter
  import rr_lock_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] IN_req,
  input  logic [NUM_REQ-1:0] IN_last,
  input  logic               IN_stall,
  output logic [NUM_REQ-1:0] OUT_grant,
  output logic               OUT_grantValid,
  output logic [ID_W-1:0]    OUT_grantIdx,
  output logic               OUT_accept,
  output logic               OUT_locked
);

  if (NUM_REQ < 2 || NUM_REQ > RR_MAX_REQ) begin : g_bad_num_req
    $error("rr_lock_arbiter: NUM_REQ out of range");
  end

  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | ID_W'(i);
    end
    return idx;
  endfunction

  ArbState_t          state_q, state_d, state_eff;
  logic [ID_W-1:0]    ptr_q, ptr_d, ptr_eff;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0] hi_mask, req_hi, hi_pre, all_pre, hi_first, all_first;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx, ptr_inc;
  logic               grant_last, accept;

  // Outputs in a reset cycle are computed as if the registers already held reset values.
  assign state_eff = rst ? ARB_IDLE : state_q;
  assign ptr_eff   = rst ? '0 : ptr_q;

  assign hi_mask = ~((NUM_REQ'(1) << ptr_eff) - NUM_REQ'(1));
  assign req_hi  = IN_req & hi_mask;

  PrefixRed #(.W(NUM_REQ), .FUNC(0), .START(0)) u_pre_hi (
    .in_i  (req_hi),
    .out_o (hi_pre)
  );

  PrefixRed #(.W(NUM_REQ), .FUNC(0), .START(0)) u_pre_all (
    .in_i  (IN_req),
    .out_o (all_pre)
  );

  assign hi_first  = req_hi & ~(hi_pre << 1);
  assign all_first = IN_req & ~(all_pre << 1);

  always_comb begin
    grant = '0;
    if (state_eff == ARB_LOCKED) begin
      if (IN_req[owner_q]) grant = NUM_REQ'(1) << owner_q;
    end else begin
      grant = (|req_hi) ? hi_first : all_first;
    end
  end

  assign grant_idx  = onehot_to_idx(grant);
  assign grant_last = |(grant & IN_last);
  assign accept     = (|grant) & ~IN_stall;
  assign ptr_inc    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (accept) begin
      if (grant_last) begin
        state_d = ARB_IDLE;
        ptr_d   = ptr_inc;
      end else begin
        state_d = ARB_LOCKED;
        owner_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign OUT_grant      = grant;
  assign OUT_grantValid = |grant;
  assign OUT_grantIdx   = grant_idx;
  assign OUT_accept     = accept;
  assign OUT_locked     = (state_eff == ARB_LOCKED);

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Scoreboard bench for rr_lock_arbiter: directed scenarios then random traffic vs. a circular-search model.
module tb_rr_lock_arbiter;

  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk;
  logic          rst;
  logic [N-1:0]  IN_req;
  logic [N-1:0]  IN_last;
  logic          IN_stall;
  logic [N-1:0]  OUT_grant;
  logic          OUT_grantValid;
  logic [IW-1:0] OUT_grantIdx;
  logic          OUT_accept;
  logic          OUT_locked;

  rr_lock_arbiter #(.NUM_REQ(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .IN_req         (IN_req),
    .IN_last        (IN_last),
    .IN_stall       (IN_stall),
    .OUT_grant      (OUT_grant),
    .OUT_grantValid (OUT_grantValid),
    .OUT_grantIdx   (OUT_grantIdx),
    .OUT_accept     (OUT_accept),
    .OUT_locked     (OUT_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int grant;
    int idx;
    int accept;
    int locked;
    int ptr;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;

  // Reference model registers
  int m_ptr    = 0;
  int m_locked = 0;
  int m_owner  = 0;

  task automatic chk(input string nm, input int act, input int exp, input int cyc);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
  endtask

  // Who wins: the owner if locked, else the first requester met walking up from ptr circularly.
  function automatic int pick(input logic [N-1:0] req, input int ptr, input int locked, input int owner);
    if (locked != 0) return req[owner] ? owner : -1;
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] last, input bit stall, input bit r);
    exp_t e;
    int g, p_eff, l_eff;
    IN_req   = req;
    IN_last  = last;
    IN_stall = stall;
    rst      = r;
    p_eff = r ? 0 : m_ptr;
    l_eff = r ? 0 : m_locked;
    g = pick(req, p_eff, l_eff, m_owner);
    e.grant  = (g < 0) ? 0 : (1 << g);
    e.idx    = (g < 0) ? 0 : g;
    e.accept = (g >= 0 && !stall) ? 1 : 0;
    e.locked = l_eff;
    e.ptr    = m_ptr;
    e.cyc    = cyc_n;
    sb.push_back(e);
    if (r) begin
      m_ptr = 0; m_locked = 0; m_owner = 0;
    end else if (e.accept != 0) begin
      if (last[g]) begin
        m_locked = 0;
        m_ptr    = (g + 1) % N;
      end else begin
        m_locked = 1;
        m_owner  = g;
      end
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("grant",  int'(OUT_grant),      mon_e.grant,          mon_e.cyc);
      chk("idx",    int'(OUT_grantIdx),   mon_e.idx,            mon_e.cyc);
      chk("valid",  int'(OUT_grantValid), (mon_e.grant != 0) ? 1 : 0, mon_e.cyc);
      chk("accept", int'(OUT_accept),     mon_e.accept,         mon_e.cyc);
      chk("locked", int'(OUT_locked),     mon_e.locked,         mon_e.cyc);
      chk("ptr",    int'(dut.ptr_q),      mon_e.ptr,            mon_e.cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] rq, lt;
    bit st, rs;
    rst = 1'b1; IN_req = '0; IN_last = '0; IN_stall = 1'b0;
    @(posedge clk);
    #1;
    cycle(8'h00, 8'h00, 0, 1);

    // Rotation over 2,5,7 with single beats
    repeat (4) cycle(8'b1010_0100, 8'hFF, 0, 0);
    // Move ptr to 6, then fallback wraps to requester 0
    cycle(8'b0010_0000, 8'hFF, 0, 0);
    cycle(8'b0000_0011, 8'hFF, 0, 0);
    cycle(8'b0000_0010, 8'hFF, 0, 0);
    // Requester 3 three-beat transfer while 1 waits
    cycle(8'b0000_1010, 8'b0000_0000, 0, 0);
    cycle(8'b0000_1010, 8'b0000_0000, 0, 0);
    cycle(8'b0000_1010, 8'b0000_1000, 0, 0);
    cycle(8'b0000_0010, 8'hFF, 0, 0);
    // Stall for four cycles, then accept
    repeat (4) cycle(8'b0001_0000, 8'hFF, 1, 0);
    cycle(8'b0001_0000, 8'hFF, 0, 0);
    // Lock on 4, owner drops request, then returns and finishes
    cycle(8'b0001_0000, 8'h00, 0, 0);
    repeat (2) cycle(8'b0000_0001, 8'h00, 0, 0);
    cycle(8'b0001_0001, 8'b0001_0000, 0, 0);
    // Reset while locked with an accept pending
    cycle(8'b0000_0100, 8'h00, 0, 0);
    cycle(8'b0000_0100, 8'h00, 0, 1);
    cycle(8'b0000_0000, 8'h00, 0, 0);
    cycle(8'b1000_0000, 8'hFF, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      rq = N'($urandom);
      if ($urandom_range(0, 3) == 0) rq = rq & N'($urandom);
      lt = N'($urandom);
      st = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 59) == 0);
      cycle(rq, lt, st, rs);
    end

    @(negedge clk);
    #1;
    chk("drain", sb.size(), 0, cyc_n);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_lock_arbiter.md
# rr_lock_arbiter

Round-robin arbiter that shares one single-ported resource (e.g. a result bus, a load/store port or a memory request channel) among `NUM_REQ` requesters. It supports multi-beat transactions through a grant lock. Selection uses prefix-OR reduction to find the first set request at or after a rotating priority pointer. A requester that wins a multi-beat transfer keeps the resource until its last beat is accepted.

## Interface
Parameters:
- `NUM_REQ`, default 8: number of requesters; legal range 2..32.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the grant index and the priority pointer.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `IN_req`, in, `NUM_REQ`: request vector, one bit per requester.
- `IN_last`, in, `NUM_REQ`: per-requester flag, "current beat is the last beat of its transaction".
- `IN_stall`, in, 1: the resource cannot accept a beat this cycle.
- `OUT_grant`, out, `NUM_REQ`: one-hot grant, or all zero.
- `OUT_grantValid`, out, 1: OR of `OUT_grant`.
- `OUT_grantIdx`, out, `ID_W`: binary index of the granted requester; 0 when no grant.
- `OUT_accept`, out, 1: a beat transfers this cycle; equals `OUT_grantValid & ~IN_stall`.
- `OUT_locked`, out, 1: the arbiter is in state LOCKED.

## Operation
- Registered state: `state` ∈ {IDLE, LOCKED}, priority pointer `ptr` (`ID_W` bits), lock owner `owner` (`ID_W` bits).
- Reset values: `state`=IDLE, `ptr`=0, `owner`=0.
  - Outputs during the reset cycle follow the combinational rules below, evaluated from the reset state.
- Selection in IDLE:
  - `hi` = `IN_req` masked to bits ≥ `ptr`.
  - If `hi` ≠ 0, grant the lowest set bit of `hi`; otherwise grant the lowest set bit of `IN_req`.
  - Lowest set bit = `v & ~(prefixOR(v) << 1)`.
- Selection in LOCKED:
  - `OUT_grant` = `IN_req[owner]` ? onehot(`owner`) : 0.
  - No other requester is ever granted while LOCKED.
- Accept on an edge with `OUT_accept`=1 and granted index g:
  - If `IN_last[g]`=1: `state`←IDLE and `ptr`←(g+1) mod `NUM_REQ`. For non-power-of-2 `NUM_REQ`, wrap from `NUM_REQ-1` to 0.
  - If `IN_last[g]`=0: `state`←LOCKED, `owner`←g, and `ptr` is unchanged.
- No accept: `state`, `ptr` and `owner` hold.
  - Applies to a stall, an empty request vector, or the owner dropping its request while LOCKED.
- Grants are recomputed every cycle from the current `IN_req`. Requesters hold `req` and `last` stable until accepted; the arbiter relies on that but does not check it.
- `IN_last` bits of requesters that are not granted are ignored.

## Timing
- Grant is combinational: same-cycle from `IN_req`, `ptr`, `state` and `owner`. There is no register stage on the grant outputs.
- State update latency: 1 cycle. The new `ptr`/`state` take effect on the cycle after the accept edge.
- `IN_stall`=1:
  - `OUT_grant` is still driven; `OUT_accept`=0.
  - Pointer and state freeze, so the same winner is presented next cycle if requests are unchanged.
- Single-beat throughput: one accept per cycle. Back-to-back accepts rotate fairly, and each requester is served at least once per `NUM_REQ` accepted transactions.
- Reset mid-transaction: a synchronous `rst` while LOCKED returns to IDLE, `ptr`=0 on the next edge. The owner's partial transaction is abandoned.
- Simultaneous `rst` and accept: `rst` wins.

## Structure
- Shared package entries:
  - constant `RR_MAX_REQ` = 32;
  - enum type `ArbState_t` {ARB_IDLE, ARB_LOCKED}.
- The existing PrefixRed sub-module is instantiated twice, both with FUNC=0 (OR) and START=0: once on the masked vector, once on the unmasked vector.
- A small local function converts one-hot to index for `OUT_grantIdx`.
- Expected size: ~150 lines of RTL.

## Test plan
- Reset, then `IN_req`=8'b1010_0100 with all `last`=1, no stall:
  - grants idx 2, 5, 7, then 2;
  - `ptr` goes 3, 6, 0, 3;
  - `OUT_accept`=1 each cycle.
- `ptr`=6, `IN_req`=8'b0000_0011 → grant idx 0, since the unmasked fallback wraps around.
- Requester 3 issues a 3-beat transfer (`last`=0,0,1) while requester 1 also requests:
  - `OUT_locked`=1 after beat 1;
  - grant stays on 3 for all three beats;
  - requester 1 is granted on the cycle after beat 3 is accepted.
- `IN_stall`=1 for 4 cycles with `IN_req`=8'b0001_0000:
  - `OUT_grant`=8'b0001_0000 and `OUT_accept`=0 throughout;
  - `ptr` is unchanged;
  - the accept occurs on the first unstalled cycle.
- LOCKED on owner 4, which then drops `req` for 2 cycles while requester 0 requests:
  - `OUT_grant`=0 during those cycles;
  - `owner` and `state` hold;
  - grant returns to 4 when its request reasserts.
- `rst` asserted while LOCKED with a pending accept → next cycle `state`=IDLE, `ptr`=0, `OUT_locked`=0.
